ika87ad_mcseq: RTL

- Microcode sequencer: the reader side of the IKA87AD microcode ROM interface.
- Takes the start address from the instruction decoder, issues ROM read ticks and addresses, and latches each 18-bit microword.
- Holds each microword for the required number of bus machine cycles and advances to the next address.
- Terminates the instruction on an RD4 (opcode fetch) word, then hands control back to the decoder.

---
 rtl/ika87ad_mcseq_if.sv | 25 ++
 rtl/ika87ad_mcseq.sv | 114 +++++++++++
 2 files changed

// File: rtl/ika87ad_mcseq_if.sv
// rtl/ika87ad_mcseq_if.sv - decoder, bus controller and microcode ROM signals of the sequencer
`timescale 1ns/1ps
interface ika87ad_mcseq_if;
  logic        i_IRD_VALID;
  logic [7:0]  i_IRD_START_ADDR;
  logic        i_BUS_CYCLE_DONE;
  logic        i_FLUSH;
  logic        o_MCROM_READ_TICK;
  logic [7:0]  o_MCROM_ADDR;
  logic [17:0] i_MCROM_DATA;
  logic [17:0] o_MC_WORD;
  logic        o_MC_VALID;
  logic [1:0]  o_BUS_CYCLE;
  logic        o_INSTR_END;

  modport slave (
    input  i_IRD_VALID, i_IRD_START_ADDR, i_BUS_CYCLE_DONE, i_FLUSH, i_MCROM_DATA,
    output o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID, o_BUS_CYCLE, o_INSTR_END
  );

  modport master (
    output i_IRD_VALID, i_IRD_START_ADDR, i_BUS_CYCLE_DONE, i_FLUSH, i_MCROM_DATA,
    input  o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID, o_BUS_CYCLE, o_INSTR_END
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// rtl/ika87ad_mcseq.sv - microcode sequencer: fetches, holds and steps IKA87AD microwords
`timescale 1ns/1ps
module ika87ad_mcseq #(
  parameter logic [7:0]  P_IRD_ADDR = 8'd255,
  parameter logic [17:0] P_NOP_WORD = 18'h3C000
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_CEN,
  ika87ad_mcseq_if.slave   bus
);

  localparam logic [1:0] BC_RD4  = 2'b00;
  localparam logic [1:0] MCTYPE3 = 2'b11;

  typedef enum logic [1:0] {S_WAIT, S_ROM, S_LATCH, S_EXEC} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        tick_q, tick_d;
  logic [17:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        end_q, end_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rep_dec;

  // Only MCTYPE3 words with the repeat flag carry a hold count.
  assign rep_dec = (bus.i_MCROM_DATA[17:16] == MCTYPE3 && bus.i_MCROM_DATA[13])
                   ? bus.i_MCROM_DATA[12:9] : 4'd0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = 1'b0;
    word_d  = word_q;
    valid_d = valid_q;
    end_d   = 1'b0;
    cnt_d   = cnt_q;
    if (bus.i_FLUSH) begin
      state_d = S_WAIT;
      addr_d  = P_IRD_ADDR;
      word_d  = P_NOP_WORD;
      valid_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (bus.i_IRD_VALID) begin
            addr_d  = bus.i_IRD_START_ADDR;
            tick_d  = 1'b1;
            state_d = S_ROM;
          end
        end
        S_ROM: begin
          state_d = S_LATCH;
        end
        S_LATCH: begin
          word_d  = bus.i_MCROM_DATA;
          valid_d = 1'b1;
          cnt_d   = rep_dec;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (bus.i_BUS_CYCLE_DONE) begin
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else if (word_q[1:0] != BC_RD4) begin
              addr_d  = addr_q + 8'd1;
              tick_d  = 1'b1;
              valid_d = 1'b0;
              state_d = S_ROM;
            end else begin
              end_d   = 1'b1;
              valid_d = 1'b0;
              word_d  = P_NOP_WORD;
              addr_d  = P_IRD_ADDR;
              state_d = S_WAIT;
            end
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // Disabled edges hold every register, so the pulses stretch with i_CEN.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= S_WAIT;
      addr_q  <= P_IRD_ADDR;
      tick_q  <= 1'b0;
      word_q  <= P_NOP_WORD;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else if (i_CEN) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_MCROM_READ_TICK = tick_q;
  assign bus.o_MCROM_ADDR      = addr_q;
  assign bus.o_MC_WORD         = word_q;
  assign bus.o_MC_VALID        = valid_q;
  assign bus.o_BUS_CYCLE       = word_q[1:0];
  assign bus.o_INSTR_END       = end_q;

endmodule
